// File: rtl/booth_mult_bist.sv
// Radix-2 sequential Booth multiplier with a built-in self test: an LFSR feeds
// operand pairs, each result is checked against a combinational reference and folded into a MISR.
module booth_mult_bist #(
  parameter int          WIDTH      = 8,
  parameter int          N_PATTERNS = 16,
  parameter logic [63:0] LFSR_SEED  = 64'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 test,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 fault_inj,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic                 bist_done,
  output logic                 pass,
  output logic [2*WIDTH-1:0]   signature
);
  localparam int PW  = 2*WIDTH;
  localparam int CW  = $clog2(WIDTH);
  localparam int PCW = $clog2(N_PATTERNS+1);

  // Maximal-length feedback taps indexed by register length (bit t-1 set for tap t).
  function automatic logic [63:0] tap_mask(input int n);
    case (n)
      4:  return 64'hC;
      6:  return 64'h30;
      8:  return 64'hB8;
      10: return 64'h240;
      12: return 64'h829;
      14: return 64'h2015;
      16: return 64'hD008;
      18: return 64'h2_0400;
      20: return 64'h9_0000;
      22: return 64'h30_0000;
      24: return 64'hE1_0000;
      26: return 64'h200_0023;
      28: return 64'h900_0000;
      30: return 64'h2000_0029;
      32: return 64'h8020_0003;
      34: return 64'h2_0400_0003;
      36: return 64'h8_0100_0000;
      38: return 64'h20_0000_0031;
      40: return 64'hA0_0014_0000;
      42: return 64'h300_000C_0000;
      44: return 64'hC00_0003_0000;
      46: return 64'h3000_0300_0000;
      48: return 64'hC000_0018_0000;
      50: return 64'h3_0000_00C0_0000;
      52: return 64'h9_0000_0000_0000;
      54: return 64'h30_0000_0003_0000;
      56: return 64'hC0_0006_0000_0000;
      58: return 64'h200_0040_0000_0000;
      60: return 64'hC00_0000_0000_0000;
      62: return 64'h3000_0000_0000_0030;
      default: return 64'hD800_0000_0000_0000;
    endcase
  endfunction

  localparam logic [63:0]   TAPS_ALL = tap_mask(PW);
  localparam logic [PW-1:0] TAPS     = TAPS_ALL[PW-1:0];
  localparam logic [PW-1:0] SEED     = LFSR_SEED[PW-1:0];

  typedef enum logic [2:0] {IDLE, RUN, DONE, B_LOAD, B_RUN, B_CHK, B_END} state_t;

  state_t           state;
  logic [WIDTH:0]   acc, mcand, sum, acc_n;
  logic [WIDTH-1:0] q, q_n;
  logic             q_1, q1_n, err, mismatch;
  logic [CW-1:0]    cnt;
  logic [PCW-1:0]   pcnt;
  logic [PW-1:0]    lfsr, misr, chk_res, lfsr_n, misr_n;
  logic signed [PW-1:0] ref_a, ref_b, ref_prod;

  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  // Arithmetic right shift of {acc, q, q_1}; acc carries one guard bit so -2^(W-1) squared cannot overflow.
  assign {acc_n, q_n, q1_n} = {sum[WIDTH], sum, q};

  assign ref_a    = PW'($signed(lfsr[WIDTH-1:0]));
  assign ref_b    = PW'($signed(lfsr[PW-1:WIDTH]));
  assign ref_prod = ref_a * ref_b;
  assign chk_res  = {acc[WIDTH-1:0], q} ^ {{(PW-1){1'b0}}, fault_inj};
  assign mismatch = (chk_res != ref_prod);
  assign lfsr_n   = {lfsr[PW-2:0], ^(lfsr & TAPS)};
  assign misr_n   = {misr[PW-2:0], ^(misr & TAPS)} ^ chk_res;
  assign signature = misr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      q         <= '0;
      q_1       <= 1'b0;
      cnt       <= '0;
      pcnt      <= '0;
      lfsr      <= SEED;
      misr      <= '0;
      err       <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bist_done <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (test) begin
            pass  <= 1'b0;
            misr  <= '0;
            lfsr  <= SEED;
            err   <= 1'b0;
            pcnt  <= '0;
            state <= B_LOAD;
          end else begin
            mcand <= {a[WIDTH-1], a};
            q     <= b;
            acc   <= '0;
            q_1   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN, B_RUN: begin
          acc <= acc_n;
          q   <= q_n;
          q_1 <= q1_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            if (state == RUN) begin
              product <= {acc_n[WIDTH-1:0], q_n};
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              state <= B_CHK;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        B_LOAD: begin
          mcand <= {lfsr[WIDTH-1], lfsr[WIDTH-1:0]};
          q     <= lfsr[PW-1:WIDTH];
          acc   <= '0;
          q_1   <= 1'b0;
          cnt   <= '0;
          state <= B_RUN;
        end
        B_CHK: begin
          if (mismatch) err <= 1'b1;
          misr    <= misr_n;
          product <= chk_res;
          lfsr    <= lfsr_n;
          pcnt    <= pcnt + 1'b1;
          if (pcnt == PCW'(N_PATTERNS-1)) begin
            busy      <= 1'b0;
            bist_done <= 1'b1;
            pass      <= !(err || mismatch);
            state     <= B_END;
          end else begin
            state <= B_LOAD;
          end
        end
        B_END: begin
          bist_done <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_bist.sv
// Directed/randomised bench for booth_mult_bist: a WIDTH=4 and a WIDTH=8 instance share clock and reset.
module tb_booth_mult_bist;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 0, test4 = 0, fault4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] p4, sig4;
  logic       busy4, done4, bd4, pass4;

  logic        start8 = 0, test8 = 0, fault8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8, sig8;
  logic        busy8, done8, bd8, pass8;

  int checks = 0;
  int errors = 0;

  booth_mult_bist #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .test(test4), .a(a4), .b(b4),
    .fault_inj(fault4), .product(p4), .busy(busy4), .done(done4),
    .bist_done(bd4), .pass(pass4), .signature(sig4));

  booth_mult_bist #(.WIDTH(8), .N_PATTERNS(16), .LFSR_SEED(64'd1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .test(test8), .a(a8), .b(b8),
    .fault_inj(fault8), .product(p8), .busy(busy8), .done(done8),
    .bist_done(bd8), .pass(pass8), .signature(sig8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference BIST: 16-bit LFSR x^16+x^15+x^13+x^4+1 seeded 1, plain signed products, same-polynomial MISR.
  task automatic bist_model(input bit flt, output logic [15:0] sig, output logic [15:0] last);
    logic [15:0] l, m, pv;
    byte sa, sb;
    int pr;
    l = 16'h0001;
    m = 16'h0000;
    pv = 16'h0000;
    for (int p = 0; p < 16; p++) begin
      sa = l[7:0];
      sb = l[15:8];
      pr = int'(sa) * int'(sb);
      pv = pr[15:0] ^ {15'b0, flt};
      m  = {m[14:0], ^(m & 16'hD008)} ^ pv;
      l  = {l[14:0], ^(l & 16'hD008)};
    end
    sig  = m;
    last = pv;
  endtask

  task automatic run_mul(input string tag, input int w, input int av, input int bv,
                         input bit mid_restart, input bit flt);
    logic [15:0] expv, prod;
    int pr, done_at, dones, busy_n, bd_n;
    pr = av * bv;
    expv = (w == 4) ? {8'h00, pr[7:0]} : pr[15:0];
    done_at = -1; dones = 0; busy_n = 0; bd_n = 0;
    @(negedge clk);
    if (w == 4) begin a4 = av[3:0]; b4 = bv[3:0]; test4 = 0; start4 = 1; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; test8 = 0; fault8 = flt; start8 = 1; end
    for (int c = 1; c <= 2*w + 6; c++) begin
      @(negedge clk);
      if (c == 1) begin start4 = 0; start8 = 0; end
      if (mid_restart && c == 2) begin start8 = 1; a8 = 8'h11; b8 = 8'h22; end
      if (mid_restart && c == 3) start8 = 0;
      if ((w == 4) ? busy4 : busy8) busy_n++;
      if ((w == 4) ? bd4 : bd8) bd_n++;
      if ((w == 4) ? done4 : done8) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
    end
    prod = (w == 4) ? {8'h00, p4} : p8;
    chk({tag, "_latency"}, 64'(done_at), 64'(w + 1));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(w));
    chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
    chk({tag, "_no_bist_done"}, 64'(bd_n), 64'd0);
    chk({tag, "_product"}, 64'(prod), 64'(expv));
    fault8 = 0;
  endtask

  task automatic run_bist(input string tag, input bit flt, output logic [15:0] sig_out);
    logic [15:0] exp_sig, exp_last;
    bit seen, gap, dn;
    bist_model(flt, exp_sig, exp_last);
    seen = 0; gap = 0; dn = 0;
    @(negedge clk);
    start8 = 1; test8 = 1; fault8 = flt;
    @(negedge clk);
    start8 = 0; test8 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bd8) begin seen = 1; break; end
      if (!busy8) gap = 1;
      if (done8) dn = 1;
      @(negedge clk);
    end
    chk({tag, "_bist_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_continuous"}, 64'(gap), 64'd0);
    chk({tag, "_no_done"}, 64'(dn), 64'd0);
    chk({tag, "_busy_low_at_end"}, 64'(busy8), 64'd0);
    chk({tag, "_pass"}, 64'(pass8), 64'(!flt));
    chk({tag, "_signature"}, 64'(sig8), 64'(exp_sig));
    chk({tag, "_last_product"}, 64'(p8), 64'(exp_last));
    repeat (3) @(negedge clk);
    chk({tag, "_pulse_ended"}, 64'(bd8), 64'd0);
    chk({tag, "_verdict_held"}, {47'b0, pass8, sig8}, {47'b0, !flt, exp_sig});
    sig_out = sig8;
    fault8 = 0;
  endtask

  initial begin
    logic [15:0] sig_clean, sig_fault;
    int ra, rb, nd;
    #1;
    chk("reset_out4", {44'b0, busy4, done4, bd4, pass4, p4, sig4}, 64'd0);
    chk("reset_out8", {28'b0, busy8, done8, bd8, pass8, p8, sig8}, 64'd0);
    @(negedge clk);
    rst_n = 1;

    run_mul("w4_4x7", 4, 4, 7, 0, 0);
    run_mul("w4_m4x5", 4, -4, 5, 0, 0);
    run_mul("w4_m8xm8", 4, -8, -8, 0, 0);
    run_mul("w8_m128x127_restart", 8, -128, 127, 1, 1);
    run_mul("w8_m128xm128", 8, -128, -128, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom_range(255) - 128;
      rb = $urandom_range(255) - 128;
      run_mul($sformatf("w8_rand%0d", i), 8, ra, rb, 0, 0);
    end
    for (int i = 0; i < 2; i++) begin
      ra = $urandom_range(15) - 8;
      rb = $urandom_range(15) - 8;
      run_mul($sformatf("w4_rand%0d", i), 4, ra, rb, 0, 0);
    end

    run_bist("bist_clean", 0, sig_clean);
    run_bist("bist_fault", 1, sig_fault);
    chk("bist_sig_differs", 64'(sig_clean != sig_fault), 64'd1);

    // Abort a multiply mid-run with reset.
    @(negedge clk);
    a4 = 4'd3; b4 = 4'hE; start4 = 1;
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_out4", {44'b0, busy4, done4, bd4, pass4, p4, sig4}, 64'd0);
    chk("rst_mid_out8", {28'b0, busy8, done8, bd8, pass8, p8, sig8}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4 || bd4) nd++;
    end
    chk("rst_no_done", 64'(nd), 64'd0);
    run_mul("w4_after_rst_3xm2", 4, 3, -2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
